// File: rtl/acc_array_if.sv
// acc_array_if: control, operand and result bundle for acc_array.
//   master : drives run_i/len_i/clear_i/valid_i/number_i, observes results
//   slave  : the accumulator side (acc_array)
// Lane k of number_i sits at [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]; result_o
// packs the lane sums in the same order at [k*DWIDTH +: DWIDTH].
interface acc_array_if #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int unsigned CNT_WIDTH     = 16
);
    logic                            run_i;
    logic [CNT_WIDTH-1:0]            len_i;
    logic                            clear_i;
    logic                            valid_i;
    logic [NUM_CH*IN_DATA_WIDTH-1:0] number_i;
    logic                            ready_o;
    logic                            busy_o;
    logic                            valid_o;
    logic [NUM_CH*DWIDTH-1:0]        result_o;
    logic                            overflow_o;

    modport master (
        output run_i, len_i, clear_i, valid_i, number_i,
        input  ready_o, busy_o, valid_o, result_o, overflow_o
    );

    modport slave (
        input  run_i, len_i, clear_i, valid_i, number_i,
        output ready_o, busy_o, valid_o, result_o, overflow_o
    );
endinterface

// File: rtl/acc_array.sv
// acc_array: multi-lane, length-programmed accumulator.
// Sums NUM_CH independent lanes over len_i accepted beats, then presents all
// lane sums on result_o together with a one-cycle valid_o pulse.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      acc_array_if.slave: run_i/len_i start, clear_i abort,
//            valid_i/number_i operand beats, ready_o/busy_o status,
//            valid_o/result_o/overflow_o results
// Optional build macro ACC_SAT_EN: per-lane saturating adds and a sticky
// per-run overflow_o. Without it lanes wrap and overflow_o is tied low.
module acc_array #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned SIGNED        = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    acc_array_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [NUM_CH-1:0][DWIDTH-1:0] acc_q;
    logic [NUM_CH-1:0][DWIDTH-1:0] lane_sum;
    logic [NUM_CH-1:0][DWIDTH-1:0] result_q;
    logic [CNT_WIDTH-1:0]          cnt_q;
    logic [CNT_WIDTH-1:0]          len_q;
    logic                          beat_acc;
    logic                          last_beat;
`ifdef ACC_SAT_EN
    logic [NUM_CH-1:0]             lane_sat;
    logic                          ovf_q;
`endif

    assign beat_acc  = (state == RUN) && bus.valid_i;
    // cnt_q counts beats already taken, so this beat is number cnt_q+1.
    assign last_beat = beat_acc && ((cnt_q + CNT_WIDTH'(1)) == len_q);

    // Per-lane next sum for the beat currently on number_i.
    always_comb begin
        logic [IN_DATA_WIDTH-1:0] opnd;
        logic [DWIDTH-1:0]        ext;
`ifdef ACC_SAT_EN
        logic [DWIDTH:0]          wide;
`endif
        lane_sum = '0;
        opnd     = '0;
        ext      = '0;
`ifdef ACC_SAT_EN
        lane_sat = '0;
        wide     = '0;
`endif
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            opnd = bus.number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
            ext  = (SIGNED != 0) ? {{(DWIDTH-IN_DATA_WIDTH){opnd[IN_DATA_WIDTH-1]}}, opnd}
                                 : {{(DWIDTH-IN_DATA_WIDTH){1'b0}}, opnd};
`ifdef ACC_SAT_EN
            wide = {1'b0, acc_q[k]} + {1'b0, ext};
            if (SIGNED != 0) begin
                // Signed overflow: both addends share a sign the sum lacks;
                // clamp toward the sign of the addends.
                lane_sat[k] = (acc_q[k][DWIDTH-1] == ext[DWIDTH-1]) &&
                              (wide[DWIDTH-1] != acc_q[k][DWIDTH-1]);
                lane_sum[k] = !lane_sat[k]        ? wide[DWIDTH-1:0] :
                              acc_q[k][DWIDTH-1]  ? {1'b1, {(DWIDTH-1){1'b0}}} :
                                                    {1'b0, {(DWIDTH-1){1'b1}}};
            end else begin
                lane_sat[k] = wide[DWIDTH];
                lane_sum[k] = lane_sat[k] ? '1 : wide[DWIDTH-1:0];
            end
`else
            lane_sum[k] = acc_q[k] + ext;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (bus.run_i) state_nxt = (bus.len_i == '0) ? DONE : RUN;
                RUN:  if (last_beat) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
`ifdef ACC_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else if (bus.clear_i) begin
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
`ifdef ACC_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.run_i) begin
                acc_q    <= '0;
                result_q <= '0;
                cnt_q    <= '0;
                len_q    <= bus.len_i;
`ifdef ACC_SAT_EN
                ovf_q    <= 1'b0;
`endif
            end
        end else if (beat_acc) begin
            acc_q <= lane_sum;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
`ifdef ACC_SAT_EN
            ovf_q <= ovf_q | (|lane_sat);
`endif
            // Results are captured on the final beat so they are already
            // registered during the DONE cycle.
            if (last_beat) result_q <= lane_sum;
        end
    end

    assign bus.ready_o  = (state == RUN);
    assign bus.busy_o   = (state != IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result_q;
`ifdef ACC_SAT_EN
    assign bus.overflow_o = ovf_q;
`else
    assign bus.overflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_acc_array.sv
// tb_acc_array: three acc_array instances share one stimulus stream:
// c0 unsigned 32-bit lanes, c1 signed 32-bit lanes, c2 unsigned 10-bit lanes.
// A run-level model (beats remaining, true lane sums clamped or wrapped) is
// compared against every instance on each falling edge; directed sections
// add literal expectations from hand arithmetic.
module tb_acc_array;
    localparam int unsigned NCH = 4;
    localparam int unsigned IW  = 8;
    localparam int unsigned CW  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              run_i = 1'b0;
    logic [CW-1:0]     len_i = '0;
    logic              clear_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [NCH*IW-1:0] number_i = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acc_array_if #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(32), .CNT_WIDTH(CW)) bus_def ();
    acc_array_if #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(32), .CNT_WIDTH(CW)) bus_sgn ();
    acc_array_if #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(10), .CNT_WIDTH(CW)) bus_nar ();

    assign bus_def.run_i = run_i;   assign bus_sgn.run_i = run_i;   assign bus_nar.run_i = run_i;
    assign bus_def.len_i = len_i;   assign bus_sgn.len_i = len_i;   assign bus_nar.len_i = len_i;
    assign bus_def.clear_i = clear_i; assign bus_sgn.clear_i = clear_i; assign bus_nar.clear_i = clear_i;
    assign bus_def.valid_i = valid_i; assign bus_sgn.valid_i = valid_i; assign bus_nar.valid_i = valid_i;
    assign bus_def.number_i = number_i; assign bus_sgn.number_i = number_i; assign bus_nar.number_i = number_i;

    acc_array #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(32), .CNT_WIDTH(CW), .SIGNED(0))
        u_def (.clk(clk), .reset_n(reset_n), .bus(bus_def));
    acc_array #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(32), .CNT_WIDTH(CW), .SIGNED(1))
        u_sgn (.clk(clk), .reset_n(reset_n), .bus(bus_sgn));
    acc_array #(.NUM_CH(NCH), .IN_DATA_WIDTH(IW), .DWIDTH(10), .CNT_WIDTH(CW), .SIGNED(0))
        u_nar (.clk(clk), .reset_n(reset_n), .bus(bus_nar));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level reference model ----------------
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;
    int     phase = PH_IDLE;
    int     remaining = 0;
    longint acc_m [3][NCH];
    longint res_m [3][NCH];
    bit     ovf_m [3];

    function automatic int dw(input int c);
        return (c == 2) ? 10 : 32;
    endfunction

    function automatic longint lane_val(input int c, input logic [7:0] b);
        longint v;
        v = longint'(b);
        if (c == 1 && b >= 8'd128) v = v - 256;
        return v;
    endfunction

    task automatic model_reset();
        phase = PH_IDLE;
        remaining = 0;
        for (int c = 0; c < 3; c++) begin
            ovf_m[c] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc_m[c][k] = 0;
                res_m[c][k] = 0;
            end
        end
    endtask

    task automatic add_lane(input int c, input int k, input longint v);
        longint one, s, lo, hi;
        one = 1;
        s = acc_m[c][k] + v;
        if (c == 1) begin
            lo = -(one << (dw(c) - 1));
            hi = (one << (dw(c) - 1)) - 1;
        end else begin
            lo = 0;
            hi = (one << dw(c)) - 1;
        end
`ifdef ACC_SAT_EN
        if (s > hi) begin s = hi; ovf_m[c] = 1'b1; end
        else if (s < lo) begin s = lo; ovf_m[c] = 1'b1; end
`else
        if (s > hi) s = s - (one << dw(c));
        else if (s < lo) s = s + (one << dw(c));
`endif
        acc_m[c][k] = s;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        if (clear_i) begin
            model_reset();
        end else if (phase == PH_IDLE) begin
            if (run_i) begin
                model_reset();
                if (len_i == 0) phase = PH_DONE;
                else begin remaining = int'(len_i); phase = PH_RUN; end
            end
        end else if (phase == PH_RUN) begin
            if (valid_i) begin
                for (int c = 0; c < 3; c++)
                    for (int k = 0; k < NCH; k++)
                        add_lane(c, k, lane_val(c, number_i[k*IW +: IW]));
                remaining--;
                if (remaining == 0) begin
                    for (int c = 0; c < 3; c++)
                        for (int k = 0; k < NCH; k++) res_m[c][k] = acc_m[c][k];
                    phase = PH_DONE;
                end
            end
        end else begin
            phase = PH_IDLE;
        end
    endtask

    task automatic cmp_dut(input int c, input logic rdy, input logic bsy, input logic vld,
                           input logic ovf, input logic [127:0] res);
        logic [127:0] mask;
        logic [127:0] lane;
        mask = (128'd1 << dw(c)) - 128'd1;
        chk($sformatf("c%0d.ready_o", c), 64'(rdy), 64'(phase == PH_RUN));
        chk($sformatf("c%0d.busy_o", c), 64'(bsy), 64'(phase != PH_IDLE));
        chk($sformatf("c%0d.valid_o", c), 64'(vld), 64'(phase == PH_DONE));
        chk($sformatf("c%0d.overflow_o", c), 64'(ovf), 64'(ovf_m[c]));
        for (int k = 0; k < NCH; k++) begin
            lane = (res >> (k * dw(c))) & mask;
            chk($sformatf("c%0d.result_lane%0d", c, k), lane[63:0],
                64'(res_m[c][k]) & mask[63:0]);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            cmp_dut(0, bus_def.ready_o, bus_def.busy_o, bus_def.valid_o, bus_def.overflow_o, 128'(bus_def.result_o));
            cmp_dut(1, bus_sgn.ready_o, bus_sgn.busy_o, bus_sgn.valid_o, bus_sgn.overflow_o, 128'(bus_sgn.result_o));
            cmp_dut(2, bus_nar.ready_o, bus_nar.busy_o, bus_nar.valid_o, bus_nar.overflow_o, 128'(bus_nar.result_o));
            if (reset_n) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic [CW-1:0] l, input logic cl,
                         input logic v, input logic [NCH*IW-1:0] n);
        run_i = r; len_i = l; clear_i = cl; valid_i = v; number_i = n;
    endtask

    function automatic logic [NCH*IW-1:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                             input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        logic gap_pat [4];
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) cyc();
        chk("reset.busy_o", 64'(bus_def.busy_o), 64'd0);
        chk("reset.result_o", 64'(bus_def.result_o[63:0]), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Basic sum: len 3, lane0 10/20/30, lane3 1/1/1
        drive(1, 3, 0, 0, '0); cyc();
        drive(0, 0, 0, 1, pk(10, 0, 0, 1)); cyc();
        drive(0, 0, 0, 1, pk(20, 0, 0, 1)); cyc();
        drive(0, 0, 0, 1, pk(30, 0, 0, 1)); cyc();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("basic.valid_o", 64'(bus_def.valid_o), 64'd1);
        chk("basic.lane0", 64'(bus_def.result_o[31:0]), 64'd60);
        chk("basic.lane3", 64'(bus_def.result_o[127:96]), 64'd3);
        cyc();
        @(negedge clk);
        chk("basic.busy_after", 64'(bus_def.busy_o), 64'd0);
        chk("basic.hold_lane0", 64'(bus_def.result_o[31:0]), 64'd60);
        cyc();

        // Beat gaps: len 2, valid pattern 1,0,0,1, lane1 = 7
        drive(1, 2, 0, 0, '0); cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, gap_pat[i], pk(0, 7, 0, 0));
            if (!gap_pat[i]) begin
                @(negedge clk);
                chk("gap.ready_o", 64'(bus_def.ready_o), 64'd1);
            end
            cyc();
        end
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("gap.valid_o", 64'(bus_def.valid_o), 64'd1);
        chk("gap.lane1", 64'(bus_def.result_o[63:32]), 64'd14);
        cyc();

        // Signed mode: len 4, all lanes 8'hFF
        drive(1, 4, 0, 0, '0); cyc();
        repeat (4) begin drive(0, 0, 0, 1, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF)); cyc(); end
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("signed.lane0", 64'(bus_sgn.result_o[31:0]), 64'hFFFF_FFFC);
        chk("signed.lane2", 64'(bus_sgn.result_o[95:64]), 64'hFFFF_FFFC);
        chk("signed.unsigned_lane0", 64'(bus_def.result_o[31:0]), 64'd1020);
        cyc();

        // Width boundary: 10-bit lanes, len 5, lane0 = 255 (true sum 1275)
        drive(1, 5, 0, 0, '0); cyc();
        repeat (5) begin drive(0, 0, 0, 1, pk(255, 0, 0, 0)); cyc(); end
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
`ifdef ACC_SAT_EN
        chk("narrow.lane0", 64'(bus_nar.result_o[9:0]), 64'd1023);
        chk("narrow.overflow_o", 64'(bus_nar.overflow_o), 64'd1);
`else
        chk("narrow.lane0", 64'(bus_nar.result_o[9:0]), 64'd251);
        chk("narrow.overflow_o", 64'(bus_nar.overflow_o), 64'd0);
`endif
        chk("narrow.wide_lane0", 64'(bus_def.result_o[31:0]), 64'd1275);
        cyc();

        // Abort after 2 of 4 beats; clear wins over a simultaneous valid beat
        drive(1, 4, 0, 0, '0); cyc();
        repeat (2) begin drive(0, 0, 0, 1, pk(9, 9, 9, 9)); cyc(); end
        drive(0, 0, 1, 1, pk(9, 9, 9, 9)); cyc();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("abort.valid_o", 64'(bus_def.valid_o), 64'd0);
        chk("abort.busy_o", 64'(bus_def.busy_o), 64'd0);
        chk("abort.result_o", 64'(bus_def.result_o[63:0]), 64'd0);
        cyc();
        drive(1, 1, 0, 0, '0); cyc();
        drive(0, 0, 0, 1, pk(5, 0, 0, 0)); cyc();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("after_abort.lane0", 64'(bus_def.result_o[31:0]), 64'd5);
        cyc();

        // Asynchronous reset mid-run, then a zero-length run
        drive(1, 4, 0, 0, '0); cyc();
        drive(0, 0, 0, 1, pk(3, 3, 3, 3)); cyc();
        drive(0, 0, 0, 0, '0);
        reset_n = 1'b0;
        #1;
        chk("async_reset.ready_o", 64'(bus_def.ready_o), 64'd0);
        chk("async_reset.busy_o", 64'(bus_def.busy_o), 64'd0);
        chk("async_reset.valid_o", 64'(bus_def.valid_o), 64'd0);
        chk("async_reset.result_o", 64'(bus_def.result_o[63:0]), 64'd0);
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        drive(1, 0, 0, 0, '0); cyc();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("len0.valid_o", 64'(bus_def.valid_o), 64'd1);
        chk("len0.result_o", 64'(bus_def.result_o[127:64]), 64'd0);
        cyc();

        // Randomized traffic: starts, ignored run_i, gaps, rare clears
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 3) == 0),
                  CW'($urandom_range(0, 6)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  (($urandom_range(0, 1) == 0) ? NCH*IW'($urandom) : pk(8'($urandom_range(160, 255)), 8'($urandom), 8'($urandom_range(0, 20)), 8'($urandom))));
            cyc();
        end
        drive(0, 0, 0, 0, '0);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
